// File: rtl/signal_watchdog_event_log_pkg.sv
`default_nettype none
// ============================================================================
// Module   : signal_watchdog_event_log_pkg
// Brief    : Shared event-line indices and helpers for the watchdog event log.
// Revision : 1.0
// ============================================================================
package signal_watchdog_event_log_pkg;

    localparam int NUM_EVENTS      = 5;
    localparam int EV_PHASE_OFFSET = 0;
    localparam int EV_EQUALIZER    = 1;
    localparam int EV_DC_SUM       = 2;
    localparam int EV_LEN_SHORT    = 3;
    localparam int EV_LEN_LONG     = 4;

    localparam int DROP_CNT_W = 16;

    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
        return (v == {DROP_CNT_W{1'b1}}) ? v : v + DROP_CNT_W'(1);
    endfunction

endpackage : signal_watchdog_event_log_pkg
`default_nettype wire

// File: rtl/signal_watchdog_event_log_fifo.sv
`default_nettype none
// ============================================================================
// Module   : event_log_fifo
// Brief    : First-word-fall-through FIFO with registered head and flush.
// Revision : 1.0
// ============================================================================
module event_log_fifo #(
    parameter int WIDTH      = 37,
    parameter int LOG2_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_flush,
    input  logic                  i_push,
    input  logic [WIDTH-1:0]      i_din,
    input  logic                  i_pop,
    output logic [WIDTH-1:0]      o_dout,
    output logic                  o_valid,
    output logic [LOG2_DEPTH:0]   o_count,
    output logic                  o_full
);
    import signal_watchdog_event_log_pkg::*;

    localparam int                DEPTH   = 1 << LOG2_DEPTH;
    localparam logic [LOG2_DEPTH:0] C_DEPTH = (LOG2_DEPTH+1)'(DEPTH);

    logic [WIDTH-1:0]      r_mem [DEPTH];
    logic [LOG2_DEPTH:0]   r_wr_ptr;
    logic [LOG2_DEPTH:0]   r_rd_ptr;
    logic [WIDTH-1:0]      r_head;

    logic                  w_empty;
    logic                  w_pop;
    logic                  w_push;
    logic [LOG2_DEPTH:0]   w_wr_nxt;
    logic [LOG2_DEPTH:0]   w_rd_nxt;
    logic [LOG2_DEPTH:0]   w_cnt_nxt;

    assign o_count  = r_wr_ptr - r_rd_ptr;
    assign w_empty  = (o_count == '0);
    assign o_full   = (o_count == C_DEPTH);
    assign o_valid  = !w_empty;
    assign o_dout   = r_head;

    assign w_pop     = i_pop && !w_empty && !i_flush;
    assign w_push    = i_push && (!o_full || w_pop) && !i_flush;
    assign w_wr_nxt  = r_wr_ptr + (LOG2_DEPTH+1)'(w_push);
    assign w_rd_nxt  = r_rd_ptr + (LOG2_DEPTH+1)'(w_pop);
    assign w_cnt_nxt = w_wr_nxt - w_rd_nxt;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[LOG2_DEPTH-1:0]] <= i_din;
        end
    end

    // The head register is refreshed whenever the head slot changes; if the new
    // head is the slot being written this cycle it comes straight from i_din.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_head   <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_wr_ptr <= w_wr_nxt;
            r_rd_ptr <= w_rd_nxt;
            if ((w_cnt_nxt != '0) && (w_pop || (w_empty && w_push))) begin
                if (w_rd_nxt == r_wr_ptr) begin
                    r_head <= i_din;
                end else begin
                    r_head <= r_mem[w_rd_nxt[LOG2_DEPTH-1:0]];
                end
            end
        end
    end

endmodule : event_log_fifo
`default_nettype wire

// File: rtl/signal_watchdog_event_log.sv
`default_nettype none
// ============================================================================
// Module   : signal_watchdog_event_log
// Brief    : Timestamped rising-edge logger for watchdog event lines.
// Revision : 1.0
// ============================================================================
module signal_watchdog_event_log #(
    parameter int TS_WIDTH   = 32,
    parameter int LOG2_DEPTH = 4,
    parameter int NUM_EVENTS = signal_watchdog_event_log_pkg::NUM_EVENTS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [NUM_EVENTS-1:0]  event_vec,
    input  logic                   pop,
    input  logic                   clear,
    output logic                   log_valid,
    output logic [NUM_EVENTS-1:0]  log_event,
    output logic [TS_WIDTH-1:0]    log_timestamp,
    output logic [LOG2_DEPTH:0]    log_count,
    output logic                   overflow,
    output logic [15:0]            dropped_count
);
    import signal_watchdog_event_log_pkg::*;

    localparam int REC_W = NUM_EVENTS + TS_WIDTH;

    logic [TS_WIDTH-1:0]    r_ts;
    logic [NUM_EVENTS-1:0]  r_prev;
    logic                   r_overflow;
    logic [15:0]            r_dropped;

    logic [NUM_EVENTS-1:0]  w_rise;
    logic                   w_record;
    logic                   w_full;
    logic                   w_drop;
    logic                   w_push;
    logic [REC_W-1:0]       w_head;

    assign w_rise   = event_vec & ~r_prev;
    assign w_record = enable && (w_rise != '0) && !clear;
    // A full FIFO still accepts a record when the head leaves in the same cycle.
    assign w_drop   = w_record && w_full && !pop;
    assign w_push   = w_record && !w_drop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ts       <= '0;
            r_prev     <= '0;
            r_overflow <= 1'b0;
            r_dropped  <= '0;
        end else begin
            r_ts   <= r_ts + TS_WIDTH'(1);
            r_prev <= event_vec;
            if (clear) begin
                r_overflow <= 1'b0;
                r_dropped  <= '0;
            end else if (w_drop) begin
                r_overflow <= 1'b1;
                r_dropped  <= sat_inc(r_dropped);
            end
        end
    end

    event_log_fifo #(
        .WIDTH      (REC_W),
        .LOG2_DEPTH (LOG2_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (clear),
        .i_push  (w_push),
        .i_din   ({w_rise, r_ts}),
        .i_pop   (pop),
        .o_dout  (w_head),
        .o_valid (log_valid),
        .o_count (log_count),
        .o_full  (w_full)
    );

    assign log_event     = w_head[REC_W-1:TS_WIDTH];
    assign log_timestamp = w_head[TS_WIDTH-1:0];
    assign overflow      = r_overflow;
    assign dropped_count = r_dropped;

endmodule : signal_watchdog_event_log
`default_nettype wire

// File: tb/tb_signal_watchdog_event_log.sv
`default_nettype none
// ============================================================================
// Module   : tb_signal_watchdog_event_log
// Brief    : Self-checking bench: vector table, scoreboard queue, corner cases.
// Revision : 1.0
// ============================================================================
module tb_signal_watchdog_event_log;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [4:0]  event_vec = '0;
    logic        pop = 1'b0;
    logic        clear = 1'b0;
    logic        log_valid;
    logic [4:0]  log_event;
    logic [31:0] log_timestamp;
    logic [4:0]  log_count;
    logic        overflow;
    logic [15:0] dropped_count;

    int tests = 0;
    int fails = 0;

    logic [36:0] q[$];
    logic [31:0] m_ts = '0;
    logic [4:0]  m_prev = '0;
    logic        m_ovf = 1'b0;
    logic [15:0] m_drop = '0;

    typedef struct {
        logic        en;
        logic [4:0]  ev;
        logic        p;
        logic        clr;
        logic [4:0]  exp_cnt;
        logic        exp_valid;
        logic [4:0]  exp_ev;
        logic [31:0] exp_ts;
    } vec_t;

    vec_t vecs[10];

    signal_watchdog_event_log #(
        .TS_WIDTH   (32),
        .LOG2_DEPTH (4),
        .NUM_EVENTS (5)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .event_vec     (event_vec),
        .pop           (pop),
        .clear         (clear),
        .log_valid     (log_valid),
        .log_event     (log_event),
        .log_timestamp (log_timestamp),
        .log_count     (log_count),
        .overflow      (overflow),
        .dropped_count (dropped_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called at a negative edge: drives inputs, retires the scoreboard head on
    // pop, advances the reference model, then checks state after the edge.
    task automatic cycle(input logic en, input logic [4:0] ev, input logic p, input logic clr);
        logic [4:0] rise;
        logic       rec;
        logic       full;
        enable = en; event_vec = ev; pop = p; clear = clr;
        #1;
        rise = ev & ~m_prev;
        rec  = en && (rise != 0) && !clr;
        if (p && !clr && q.size() > 0)
            chk("sb_pop_head", {27'd0, log_event, log_timestamp}, {27'd0, q[0]});
        if (clr) begin
            q.delete();
            m_ovf  = 1'b0;
            m_drop = '0;
        end else begin
            full = (q.size() == 16);
            if (p && q.size() > 0) void'(q.pop_front());
            if (rec) begin
                if (!full || p) q.push_back({rise, m_ts});
                else begin
                    m_ovf = 1'b1;
                    if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
                end
            end
        end
        m_prev = ev;
        m_ts   = m_ts + 32'd1;
        @(posedge clk);
        @(negedge clk);
        chk("model_count", 64'(log_count), 64'(q.size()));
        chk("model_valid", 64'(log_valid), 64'(q.size() > 0));
        chk("model_overflow", 64'(overflow), 64'(m_ovf));
        chk("model_dropped", 64'(dropped_count), 64'(m_drop));
        if (q.size() > 0)
            chk("model_head", {27'd0, log_event, log_timestamp}, {27'd0, q[0]});
    endtask

    initial begin
        logic [31:0] t0;

        vecs[0] = '{1'b1, 5'b00100, 1'b0, 1'b0, 5'd1, 1'b1, 5'b00100, 32'd0};
        vecs[1] = '{1'b1, 5'b00100, 1'b0, 1'b0, 5'd1, 1'b1, 5'b00100, 32'd0};
        vecs[2] = '{1'b1, 5'b00000, 1'b0, 1'b0, 5'd1, 1'b1, 5'b00100, 32'd0};
        vecs[3] = '{1'b1, 5'b00011, 1'b0, 1'b0, 5'd2, 1'b1, 5'b00100, 32'd0};
        vecs[4] = '{1'b1, 5'b00011, 1'b1, 1'b0, 5'd1, 1'b1, 5'b00011, 32'd3};
        vecs[5] = '{1'b0, 5'b10011, 1'b0, 1'b0, 5'd1, 1'b1, 5'b00011, 32'd3};
        vecs[6] = '{1'b1, 5'b00010, 1'b1, 1'b0, 5'd0, 1'b0, 5'b00000, 32'd0};
        vecs[7] = '{1'b1, 5'b00110, 1'b1, 1'b0, 5'd1, 1'b1, 5'b00100, 32'd7};
        vecs[8] = '{1'b1, 5'b10110, 1'b0, 1'b1, 5'd0, 1'b0, 5'b00000, 32'd0};
        vecs[9] = '{1'b1, 5'b11110, 1'b0, 1'b0, 5'd1, 1'b1, 5'b01000, 32'd9};

        // Reset state, with the first event line already high.
        event_vec = 5'b00100;
        repeat (2) @(negedge clk);
        chk("rst_valid", 64'(log_valid), 64'd0);
        chk("rst_count", 64'(log_count), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_dropped", 64'(dropped_count), 64'd0);
        chk("rst_head", {27'd0, log_event, log_timestamp}, 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            cycle(vecs[i].en, vecs[i].ev, vecs[i].p, vecs[i].clr);
            chk($sformatf("vec%0d_count", i), 64'(log_count), 64'(vecs[i].exp_cnt));
            chk($sformatf("vec%0d_valid", i), 64'(log_valid), 64'(vecs[i].exp_valid));
            if (vecs[i].exp_valid)
                chk($sformatf("vec%0d_head", i), {27'd0, log_event, log_timestamp},
                    {27'd0, vecs[i].exp_ev, vecs[i].exp_ts});
        end

        // Simultaneous rise of bits 0 and 3 at ts=100, bit 0 held high.
        cycle(1'b1, 5'b00000, 1'b0, 1'b1);
        for (int i = 0; i < 200 && m_ts != 32'd100; i++) cycle(1'b1, 5'b00000, 1'b0, 1'b0);
        cycle(1'b1, 5'b01001, 1'b0, 1'b0);
        repeat (49) cycle(1'b1, 5'b00001, 1'b0, 1'b0);
        chk("held_count", 64'(log_count), 64'd1);
        chk("held_head", {27'd0, log_event, log_timestamp}, {27'd0, 5'b01001, 32'd100});
        cycle(1'b1, 5'b00000, 1'b1, 1'b0);
        chk("held_drain", 64'(log_valid), 64'd0);

        // Overflow: 18 rises into a 16-deep FIFO.
        cycle(1'b1, 5'b00000, 1'b0, 1'b1);
        t0 = m_ts;
        for (int i = 0; i < 18; i++) begin
            cycle(1'b1, 5'b00010, 1'b0, 1'b0);
            cycle(1'b1, 5'b00000, 1'b0, 1'b0);
        end
        chk("ovf_count", 64'(log_count), 64'd16);
        chk("ovf_flag", 64'(overflow), 64'd1);
        chk("ovf_dropped", 64'(dropped_count), 64'd2);
        chk("ovf_head", {27'd0, log_event, log_timestamp}, {27'd0, 5'b00010, t0});

        // Full with rise and pop together.
        cycle(1'b1, 5'b00010, 1'b1, 1'b0);
        chk("fullpp_count", 64'(log_count), 64'd16);
        chk("fullpp_dropped", 64'(dropped_count), 64'd2);
        chk("fullpp_head", {27'd0, log_event, log_timestamp}, {27'd0, 5'b00010, t0 + 32'd2});

        // Clear beats a simultaneous pop and rise.
        cycle(1'b1, 5'b00110, 1'b1, 1'b1);
        chk("clr_count", 64'(log_count), 64'd0);
        chk("clr_overflow", 64'(overflow), 64'd0);
        chk("clr_dropped", 64'(dropped_count), 64'd0);
        cycle(1'b1, 5'b00110, 1'b0, 1'b0);
        chk("clr_norecord", 64'(log_count), 64'd0);

        // Rise while disabled is consumed by the edge detector.
        cycle(1'b1, 5'b00000, 1'b0, 1'b0);
        cycle(1'b0, 5'b00100, 1'b0, 1'b0);
        cycle(1'b0, 5'b00100, 1'b0, 1'b0);
        repeat (3) cycle(1'b1, 5'b00100, 1'b0, 1'b0);
        chk("dis_norecord", 64'(log_count), 64'd0);
        cycle(1'b1, 5'b00000, 1'b0, 1'b0);
        t0 = m_ts;
        cycle(1'b1, 5'b00100, 1'b0, 1'b0);
        chk("dis_rerise_count", 64'(log_count), 64'd1);
        chk("dis_rerise_head", {27'd0, log_event, log_timestamp}, {27'd0, 5'b00100, t0});

        // Random traffic against the scoreboard.
        for (int i = 0; i < 300; i++)
            cycle(1'b1, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 60) == 0));

        // Asynchronous reset mid-operation.
        rst = 1'b1;
        #1;
        chk("arst_valid", 64'(log_valid), 64'd0);
        chk("arst_count", 64'(log_count), 64'd0);
        chk("arst_head", {27'd0, log_event, log_timestamp}, 64'd0);
        chk("arst_overflow", 64'(overflow), 64'd0);
        q.delete(); m_ts = '0; m_prev = '0; m_ovf = 1'b0; m_drop = '0;
        event_vec = 5'b10000;
        @(negedge clk);
        rst = 1'b0;
        cycle(1'b1, 5'b10000, 1'b0, 1'b0);
        chk("arst_first", {27'd0, log_event, log_timestamp}, {27'd0, 5'b10000, 32'd0});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_signal_watchdog_event_log
`default_nettype wire
